// File: rtl/md_hilo_ctrl.sv
// Multiply/divide sequencer and HI/LO owner for the EXE stage.
// Runs a MUL_LAT-cycle multiply or a 32-step restoring divide and stalls the pipe while busy.
module md_hilo_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        op_div,
  input  logic        op_divu,
  input  logic        op_mult,
  input  logic        op_multu,
  input  logic        op_mthi,
  input  logic        op_mtlo,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        md_stall,
  output logic        md_busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_LAST = 6'd31;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        is_div_q, is_div_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q, dsr_d;
  logic [32:0] mcand_q, mcand_d;
  logic [32:0] mplier_q, mplier_d;
  logic [63:0] prod_q, prod_d;

  logic        start;
  logic        a_neg;
  logic        b_neg;
  logic [32:0] rem_shift;
  logic        fits;
  logic [31:0] diff;
  logic [63:0] prod_full;

  assign start = op_div | op_divu | op_mult | op_multu;
  assign a_neg = op_div & src1[31];
  assign b_neg = op_div & src2[31];

  // Dividend magnitude sits in quo_q and shifts out MSB-first while quotient bits shift in.
  assign rem_shift = {rem_q, quo_q[31]};
  assign fits      = rem_shift >= {1'b0, dsr_q};
  assign diff      = rem_shift[31:0] - dsr_q;

  // Sign-extended 33-bit operands make one multiplier serve both signed and unsigned forms.
  assign prod_full = {{31{mcand_q[32]}}, mcand_q} * {{31{mplier_q[32]}}, mplier_q};

  assign md_stall = resetn & ~flush &
                    (((state_q == S_IDLE) & start) | (state_q == S_MUL) | (state_q == S_DIV));
  assign md_busy  = (state_q != S_IDLE);
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through this block can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;

    case (state_q)
      S_IDLE: begin
        if (!flush) begin
          if (op_div | op_divu) begin
            state_d  = S_DIV;
            cnt_d    = '0;
            is_div_d = 1'b1;
            quo_d    = a_neg ? -src1 : src1;
            dsr_d    = b_neg ? -src2 : src2;
            rem_d    = '0;
            q_neg_d  = a_neg ^ b_neg;
            r_neg_d  = a_neg;
          end else if (op_mult | op_multu) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            is_div_d = 1'b0;
            mcand_d  = {op_mult & src1[31], src1};
            mplier_d = {op_mult & src2[31], src2};
          end else if (op_mthi) begin
            hi_d = src1;
          end else if (op_mtlo) begin
            lo_d = src1;
          end
        end
      end

      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          prod_d = prod_full;
          if (cnt_q == MUL_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          quo_d = {quo_q[30:0], fits};
          rem_d = fits ? diff : rem_shift[31:0];
          if (cnt_q == DIV_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      S_DONE: begin
        // The issuing instruction is still in EXE here, so start is deliberately not looked at.
        state_d = S_IDLE;
        if (!flush) begin
          if (is_div_q) begin
            lo_d = q_neg_q ? -quo_q : quo_q;
            hi_d = r_neg_q ? -rem_q : rem_q;
          end else begin
            hi_d = prod_q[63:32];
            lo_d = prod_q[31:0];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Self-checking bench for md_hilo_ctrl: cycle-level reference model plus directed literal checks.
module tb_md_hilo_ctrl;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        op_div, op_divu, op_mult, op_multu, op_mthi, op_mtlo;
  logic [31:0] src1, src2;
  logic        md_stall, md_busy;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  md_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .op_div   (op_div),
    .op_divu  (op_divu),
    .op_mult  (op_mult),
    .op_multu (op_multu),
    .op_mthi  (op_mthi),
    .op_mtlo  (op_mtlo),
    .src1     (src1),
    .src2     (src2),
    .md_stall (md_stall),
    .md_busy  (md_busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result {HI, LO} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] md_result(input bit is_div, input bit sgn,
                                            input logic [31:0] a, input logic [31:0] b);
    longint pa, pb, q, r;
    if (!is_div) begin
      pa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
      pb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
      return 64'(pa * pb);
    end
    if (b == 32'd0) begin
      if (sgn && a[31]) return {a, 32'h0000_0001};
      return {a, 32'hFFFF_FFFF};
    end
    if (sgn) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'({32'b0, a});
      pb = longint'({32'b0, b});
    end
    q = pa / pb;
    r = pa % pb;
    return {r[31:0], q[31:0]};
  endfunction

  // Model: cycles_left counts remaining busy cycles (last one is the write-back cycle).
  int          cycles_left;
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  logic        m_start, exp_stall, exp_busy;

  assign m_start   = op_div | op_divu | op_mult | op_multu;
  assign exp_busy  = (cycles_left != 0);
  assign exp_stall = !flush && ((cycles_left == 0) ? m_start : (cycles_left > 1));

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycles_left <= 0;
      m_hi        <= '0;
      m_lo        <= '0;
    end else if (flush) begin
      cycles_left <= 0;
    end else if (cycles_left == 0) begin
      if (m_start) begin
        {r_hi, r_lo} <= md_result(op_div | op_divu,
                                  (op_div | op_divu) ? op_div : op_mult, src1, src2);
        cycles_left  <= ((op_div | op_divu) ? DIV_LAT : MUL_LAT) + 1;
      end else if (op_mthi) begin
        m_hi <= src1;
      end else if (op_mtlo) begin
        m_lo <= src1;
      end
    end else begin
      if (cycles_left == 1) begin
        m_hi <= r_hi;
        m_lo <= r_lo;
      end
      cycles_left <= cycles_left - 1;
    end
  end

  always @(negedge clk) begin
    if (resetn && chk_en) begin
      check("cyc_stall", md_stall, exp_stall);
      check("cyc_busy",  md_busy,  exp_busy);
      check("cyc_hi",    hi,       m_hi);
      check("cyc_lo",    lo,       m_lo);
    end
  end

  task automatic clear_ops();
    {op_div, op_divu, op_mult, op_multu, op_mthi, op_mtlo} = '0;
    flush = 1'b0;
  endtask

  task automatic write_hilo(input bit to_hi, input logic [31:0] data);
    op_mthi = to_hi;
    op_mtlo = !to_hi;
    src1    = data;
    @(posedge clk); #1;
    clear_ops();
  endtask

  // kind: 0 div, 1 divu, 2 mult, 3 multu. Instruction stays in EXE until a cycle without stall.
  task automatic run_op(input int kind, input logic [31:0] a, input logic [31:0] b,
                        output int stalls);
    bit done = 1'b0;
    op_div   = (kind == 0);
    op_divu  = (kind == 1);
    op_mult  = (kind == 2);
    op_multu = (kind == 3);
    src1     = a;
    src2     = b;
    stalls   = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!md_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk); #1;
      src1 = $urandom;
      src2 = $urandom;
    end
    check("op_completes", done, 1'b1);
    @(posedge clk); #1;
    clear_ops();
    src1 = '0;
    src2 = '0;
  endtask

  task automatic do_vec(input string name, input int kind, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int stalls;
    run_op(kind, a, b, stalls);
    check({name, "_stalls"}, stalls, (kind < 2) ? DIV_LAT + 1 : MUL_LAT + 1);
    check({name, "_hi"}, hi, ehi);
    check({name, "_lo"}, lo, elo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    clear_ops();
    src1 = '0;
    src2 = '0;
    #2;
    check("rst_stall", md_stall, 1'b0);
    check("rst_busy",  md_busy,  1'b0);
    check("rst_hi",    hi,       32'h0);
    check("rst_lo",    lo,       32'h0);
    #10 resetn = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    write_hilo(1'b1, 32'h0000_1234);
    write_hilo(1'b0, 32'h0000_5678);
    check("mthi_val", hi, 32'h0000_1234);
    check("mtlo_val", lo, 32'h0000_5678);

    op_mthi = 1'b1; src1 = 32'hDEAD_BEEF; flush = 1'b1;
    @(posedge clk); #1;
    clear_ops();
    check("mthi_flushed", hi, 32'h0000_1234);

    op_divu = 1'b1; flush = 1'b1; src1 = 32'd9; src2 = 32'd2;
    #1 check("issue_flush_stall", md_stall, 1'b0);
    @(posedge clk); #1;
    clear_ops();
    check("issue_flush_busy", md_busy, 1'b0);

    // Flush in divide iteration 10: stall drops at once, HI/LO untouched.
    op_div = 1'b1; src1 = 32'd1000; src2 = 32'd3;
    @(posedge clk); #1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    #1;
    check("flush_stall_now", md_stall, 1'b0);
    check("flush_busy_now",  md_busy,  1'b1);
    @(posedge clk); #1;
    clear_ops();
    check("flush_idle", md_busy, 1'b0);
    check("flush_hi",   hi, 32'h0000_1234);
    check("flush_lo",   lo, 32'h0000_5678);

    do_vec("divu_100_7",  1, 32'd100,       32'd7,         32'd2,         32'd14);
    do_vec("div_m7_2",    0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_vec("div_ovf",     0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
    do_vec("divu_5_0",    1, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
    do_vec("div_m8_0",    0, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'h0000_0001);
    do_vec("div_7_m2",    0, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    do_vec("divu_max_1",  1, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF);
    do_vec("mult_m1_2",   2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_vec("multu_m1_2",  3, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE);
    do_vec("multu_max",   3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_vec("mult_min",    2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);

    // op_div held through DONE must not restart; MTHI in the following cycle lands normally.
    do_vec("div_100_7", 0, 32'd100, 32'd7, 32'd2, 32'd14);
    op_mthi = 1'b1; src1 = 32'h0000_00AA;
    @(posedge clk); #1;
    clear_ops();
    check("post_done_busy", md_busy, 1'b0);
    check("post_done_hi",   hi, 32'h0000_00AA);
    check("post_done_lo",   lo, 32'd14);

    // Reset during divide iteration 5.
    op_div = 1'b1; src1 = 32'd12345; src2 = 32'd11;
    @(posedge clk); #1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    #1;
    check("midrst_stall", md_stall, 1'b0);
    check("midrst_busy",  md_busy,  1'b0);
    check("midrst_hi",    hi, 32'h0);
    check("midrst_lo",    lo, 32'h0);
    clear_ops();
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    check("after_rst_busy", md_busy, 1'b0);

    do_vec("multu_small", 3, 32'd1234, 32'd5678, 32'h0, 32'd7006652);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
